// File: rtl/seg7_scan_mux_pkg.sv
// Shared constants, types and helpers for the seven-segment scan path.
// Segment bit order is g..a; a 1 in a raw pattern means the segment is lit.
package seg7_scan_mux_pkg;

  localparam int unsigned DIGITS  = 4;
  localparam int unsigned SEG_W   = 7;
  localparam int unsigned AN_W    = DIGITS;
  localparam int unsigned IDX_W   = 2;
  localparam int unsigned FRAME_W = DIGITS * SEG_W;

  localparam logic [SEG_W-1:0] SEG_OFF = 7'h7F;
  localparam logic [AN_W-1:0]  AN_OFF  = 4'hF;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_e;

  // One frame of raw patterns; element 0 is the rightmost digit (frame bits [6:0]).
  typedef logic [DIGITS-1:0][SEG_W-1:0] frame_t;

  // Hex nibble to raw lit-segment pattern, for upstream stages building frames.
  function automatic logic [SEG_W-1:0] hex_to_seg(input logic [3:0] nib);
    logic [SEG_W-1:0] pat;
    case (nib)
      4'h0: pat = 7'h3F;
      4'h1: pat = 7'h06;
      4'h2: pat = 7'h5B;
      4'h3: pat = 7'h4F;
      4'h4: pat = 7'h66;
      4'h5: pat = 7'h6D;
      4'h6: pat = 7'h7D;
      4'h7: pat = 7'h07;
      4'h8: pat = 7'h7F;
      4'h9: pat = 7'h6F;
      4'hA: pat = 7'h77;
      4'hB: pat = 7'h7C;
      4'hC: pat = 7'h39;
      4'hD: pat = 7'h5E;
      4'hE: pat = 7'h79;
      default: pat = 7'h71;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg7_scan_mux_slot_timer.sv
// Slot timebase: per-slot cycle counter, current digit index, and the
// blank-end / slot-wrap / frame-end markers the scan FSM keys off.
module seg7_scan_mux_slot_timer
  import seg7_scan_mux_pkg::*;
#(
  parameter int unsigned SLOT_CYCLES  = 50000,
  parameter int unsigned BLANK_CYCLES = 500,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  output logic [IDX_W-1:0] digit_idx,
  output logic             blank_end_c,
  output logic             slot_wrap_c,
  output logic             frame_end
);

  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] DIGIT_LAST = IDX_W'(DIGITS - 1);

  logic [CNT_W-1:0] slot_cnt_q, slot_cnt_d;
  logic [IDX_W-1:0] digit_idx_q, digit_idx_d;
  logic             frame_end_q, frame_end_d;

  assign blank_end_c = (slot_cnt_q == BLANK_LAST);
  assign slot_wrap_c = (slot_cnt_q == SLOT_LAST);

  // frame_end is computed one cycle ahead so the flop lines up with the boundary cycle.
  always_comb begin
    slot_cnt_d  = slot_wrap_c ? '0 : slot_cnt_q + CNT_W'(1);
    digit_idx_d = slot_wrap_c ? digit_idx_q + IDX_W'(1) : digit_idx_q;
    frame_end_d = (slot_cnt_d == SLOT_LAST) && (digit_idx_d == DIGIT_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt_q  <= '0;
      digit_idx_q <= '0;
      frame_end_q <= 1'b0;
    end else begin
      slot_cnt_q  <= slot_cnt_d;
      digit_idx_q <= digit_idx_d;
      frame_end_q <= frame_end_d;
    end
  end

  assign digit_idx = digit_idx_q;
  assign frame_end = frame_end_q;

endmodule

// File: rtl/seg7_scan_mux.sv
// Four-digit multiplexed seven-segment driver with a shadow frame buffer that
// is promoted only at frame boundaries, and a blanking gap ahead of every digit.
module seg7_scan_mux
  import seg7_scan_mux_pkg::*;
#(
  parameter int unsigned SLOT_CYCLES  = 50000,
  parameter int unsigned BLANK_CYCLES = 500,
  parameter int unsigned CNT_W        = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [FRAME_W-1:0] frame_in,
  input  logic               frame_load,
  output logic               load_ack,
  output logic               frame_done,
  output logic [SEG_W-1:0]   seg,
  output logic [AN_W-1:0]    an
);

  logic [IDX_W-1:0] digit_idx;
  logic             blank_end_c;
  logic             slot_wrap_c;
  logic             boundary;

  seg7_scan_mux_slot_timer #(
    .SLOT_CYCLES  (SLOT_CYCLES),
    .BLANK_CYCLES (BLANK_CYCLES),
    .CNT_W        (CNT_W)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .digit_idx   (digit_idx),
    .blank_end_c (blank_end_c),
    .slot_wrap_c (slot_wrap_c),
    .frame_end   (boundary)
  );

  scan_state_e      state_q, state_d;
  frame_t           shadow_q, shadow_d;
  frame_t           active_q, active_d;
  logic             pending_q, pending_d;
  logic             load_ack_q, load_ack_d;
  logic [SEG_W-1:0] seg_q, seg_d;
  logic [AN_W-1:0]  an_q, an_d;

  // Next state, buffer handoff and registered pin mux.
  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    active_d   = active_q;
    pending_d  = pending_q;
    load_ack_d = 1'b0;
    seg_d      = SEG_OFF;
    an_d       = AN_OFF;

    case (state_q)
      ST_BLANK: if (blank_end_c) state_d = ST_DRIVE;
      ST_DRIVE: if (slot_wrap_c) state_d = ST_BLANK;
      default:  state_d = ST_BLANK;
    endcase

    if (state_q == ST_DRIVE) begin
      an_d  = ~(AN_W'(1) << digit_idx);
      seg_d = ~active_q[digit_idx];
    end

    // Promotion takes the pre-load shadow; a same-cycle load stays pending for the next frame.
    if (boundary && pending_q) begin
      active_d   = shadow_q;
      pending_d  = 1'b0;
      load_ack_d = 1'b1;
    end
    if (frame_load) begin
      shadow_d  = frame_in;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_BLANK;
      shadow_q   <= '0;
      active_q   <= '0;
      pending_q  <= 1'b0;
      load_ack_q <= 1'b0;
      seg_q      <= SEG_OFF;
      an_q       <= AN_OFF;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      active_q   <= active_d;
      pending_q  <= pending_d;
      load_ack_q <= load_ack_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
    end
  end

  assign load_ack   = load_ack_q;
  assign frame_done = boundary;
  assign seg        = seg_q;
  assign an         = an_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Scoreboard bench for seg7_scan_mux: a cycle-count reference model predicts
// every output cycle; a negedge monitor pops and compares.
module tb_seg7_scan_mux;

  localparam int SLOT  = 8;
  localparam int BLANK = 2;
  localparam int FRAME = 4 * SLOT;

  logic        clk;
  logic        rst;
  logic [27:0] frame_in;
  logic        frame_load;
  logic        load_ack;
  logic        frame_done;
  logic [6:0]  seg;
  logic [3:0]  an;

  seg7_scan_mux #(
    .SLOT_CYCLES  (SLOT),
    .BLANK_CYCLES (BLANK),
    .CNT_W        (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_in   (frame_in),
    .frame_load (frame_load),
    .load_ack   (load_ack),
    .frame_done (frame_done),
    .seg        (seg),
    .an         (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] seg;
    logic [3:0] an;
    logic       ack;
    logic       done;
  } obs_t;

  obs_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: n is the number of clocks since reset release.
  int         n = 0;
  bit         model_live = 0;
  logic [6:0] m_active[4];
  logic [6:0] m_shadow[4];
  bit         m_pending;

  always @(posedge clk) begin
    obs_t e;
    int   p, d, pn, dn;
    bit   bnd;
    e = '{seg: 7'h7F, an: 4'hF, ack: 1'b0, done: 1'b0};
    if (rst) begin
      n = 0;
      m_pending = 0;
      for (int k = 0; k < 4; k++) begin
        m_active[k] = '0;
        m_shadow[k] = '0;
      end
      model_live = 1;
    end else if (model_live) begin
      p   = n % SLOT;
      d   = (n / SLOT) % 4;
      bnd = (p == SLOT - 1) && (d == 3);
      if (p >= BLANK) begin
        e.an  = ~(4'b0001 << d);
        e.seg = ~m_active[d];
      end
      e.ack = bnd && m_pending;
      pn = (n + 1) % SLOT;
      dn = ((n + 1) / SLOT) % 4;
      e.done = (pn == SLOT - 1) && (dn == 3);
      if (bnd && m_pending) begin
        for (int k = 0; k < 4; k++) m_active[k] = m_shadow[k];
        m_pending = 0;
      end
      if (frame_load) begin
        for (int k = 0; k < 4; k++) m_shadow[k] = frame_in[k*7 +: 7];
        m_pending = 1;
      end
      n++;
    end
    if (model_live) exp_q.push_back(e);
  end

  // Monitor: compares every output cycle and tracks pulse spacing.
  int cyc       = 0;
  int last_done = -1;
  int ack_cnt   = 0;
  int last_ack  = -1;
  int prev_ack  = -1;

  always @(negedge clk) begin
    obs_t e, got;
    cyc++;
    got = '{seg: seg, an: an, ack: load_ack, done: frame_done};
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL outputs t=%0t got seg=%h an=%b ack=%b done=%b required seg=%h an=%b ack=%b done=%b",
                 $time, got.seg, got.an, got.ack, got.done, e.seg, e.an, e.ack, e.done);
      end
    end
    checks++;
    if ($countones(~an) > 1) begin
      failures++;
      $display("FAIL an_onehot t=%0t got an=%b required at most one low", $time, an);
    end
    if (rst) begin
      last_done = -1;
    end else if (frame_done === 1'b1) begin
      if (last_done >= 0) begin
        checks++;
        if (cyc - last_done != FRAME) begin
          failures++;
          $display("FAIL done_period got %0d required %0d", cyc - last_done, FRAME);
        end
      end
      last_done = cyc;
    end
    if (load_ack === 1'b1) begin
      ack_cnt++;
      prev_ack = last_ack;
      last_ack = cyc;
    end
  end

  task automatic step(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Advance until the current cycle sits at the given position within the frame.
  task automatic goto(input int pos);
    bit found = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (n % FRAME == pos) begin
        found = 1;
        break;
      end
      step(1);
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL goto_timeout pos=%0d got n=%0d", pos, n);
    end
  endtask

  task automatic pulse_load(input logic [27:0] f);
    frame_in   = f;
    frame_load = 1'b1;
    step(1);
    frame_load = 1'b0;
  endtask

  task automatic check_int(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      failures++;
      $display("FAIL %s got %0d required %0d", name, got, req);
    end
  endtask

  initial begin
    int a0;
    logic [27:0] fa, fb;
    rst        = 1'b1;
    frame_load = 1'b0;
    frame_in   = '0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    step(40);

    // Directed frame loaded mid-frame.
    goto(10);
    a0 = ack_cnt;
    pulse_load({7'h4F, 7'h5B, 7'h06, 7'h3F});
    step(70);
    check_int("ack_single_load", ack_cnt - a0, 1);

    // Two loads before one boundary: last wins, one ack.
    goto(5);
    a0 = ack_cnt;
    pulse_load(28'h1234567);
    pulse_load(28'h0ABCDEF);
    step(40);
    check_int("ack_double_load", ack_cnt - a0, 1);

    // Load landing exactly on the boundary while another frame is pending.
    fa = 28'h5A5A5A5;
    fb = 28'hA5A5A5A;
    goto(20);
    a0 = ack_cnt;
    pulse_load(fa);
    goto(FRAME - 1);
    pulse_load(fb);
    step(70);
    check_int("ack_boundary_load", ack_cnt - a0, 2);
    check_int("ack_spacing", last_ack - prev_ack, FRAME);

    // Random load traffic.
    for (int i = 0; i < 400; i++) begin
      frame_load = ($urandom_range(0, 15) == 0);
      frame_in   = 28'($urandom);
      step(1);
    end
    frame_load = 1'b0;
    step(70);

    // Reset mid-DRIVE of digit 2 drops the pending frame.
    goto(2 * SLOT + 3);
    pulse_load(28'hFFFFFFF);
    a0  = ack_cnt;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(45);
    check_int("ack_after_reset", ack_cnt - a0, 0);

    step(2);
    check_int("scoreboard_drain", (exp_q.size() <= 1) ? 1 : 0, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
